// File: rtl/vid_timing_ctrl.sv
// rtl/vid_timing_ctrl.sv - raster sequencer feeding the gauss_filter pre-image port from a pixel RAM
module vid_timing_ctrl #(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int H_TOTAL = 1650,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5,
  parameter int V_TOTAL = 750,
  parameter int ADDR_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [7:0]        pix_rd_data,
  output logic              img_vsync,
  output logic              img_hsync,
  output logic              img_valid,
  output logic [7:0]        img_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNCW = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNCW = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_DISP * V_DISP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP_PEND} state_t;

  state_t            r_state;
  logic [HW-1:0]     r_h_cnt;
  logic [VW-1:0]     r_v_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en, r_vs1, r_hs1;
  logic              r_act2, r_vs2, r_hs2;
  logic              r_img_vs, r_img_hs, r_img_valid;
  logic [7:0]        r_img_data;
  logic              r_busy, r_frame_done;
  logic [15:0]       r_frame_cnt;

  state_t            w_nstate;
  logic [HW-1:0]     w_nh;
  logic [VW-1:0]     w_nv;
  logic              w_run, w_at_end, w_vs, w_hs, w_act, w_fd_next;

  always_comb begin
    w_run    = (r_state != S_IDLE);
    w_at_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    w_nstate = r_state;
    w_nh     = r_h_cnt;
    w_nv     = r_v_cnt;
    if (!w_run) begin
      w_nh     = '0;
      w_nv     = '0;
      w_nstate = en ? S_RUN : S_IDLE;
    end else begin
      if (r_h_cnt == H_LAST) begin
        w_nh = '0;
        w_nv = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        w_nh = r_h_cnt + 1'b1;
      end
      // Stop requests only land on the frame boundary; mid-frame they just park in STOP_PEND
      if (w_at_end) w_nstate = en ? S_RUN : S_IDLE;
      else          w_nstate = en ? S_RUN : S_STOP_PEND;
    end
    w_vs = w_run && (r_v_cnt < V_SYNCW);
    w_hs = w_run && (r_h_cnt < H_SYNCW);
    w_act = w_run && (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E)
                  && (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);
    w_fd_next = (w_nstate != S_IDLE) && (w_nh == H_LAST) && (w_nv == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_addr       <= '0;
      r_rd_en      <= 1'b0;
      r_vs1        <= 1'b0;
      r_hs1        <= 1'b0;
      r_act2       <= 1'b0;
      r_vs2        <= 1'b0;
      r_hs2        <= 1'b0;
      r_img_vs     <= 1'b0;
      r_img_hs     <= 1'b0;
      r_img_valid  <= 1'b0;
      r_img_data   <= 8'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_state <= w_nstate;
      r_h_cnt <= w_nh;
      r_v_cnt <= w_nv;
      r_busy  <= (w_nstate != S_IDLE);
      // frame_done is computed from the next counter so it coincides with the frame-end position
      r_frame_done <= w_fd_next;
      if (w_fd_next) r_frame_cnt <= r_frame_cnt + 16'd1;

      r_rd_en <= w_act;
      r_vs1   <= w_vs;
      r_hs1   <= w_hs;
      if (!w_run)       r_addr <= '0;
      else if (r_rd_en) r_addr <= (r_addr == A_LAST) ? '0 : r_addr + 1'b1;

      r_act2 <= r_rd_en;
      r_vs2  <= r_vs1;
      r_hs2  <= r_hs1;

      r_img_vs    <= r_vs2;
      r_img_hs    <= r_hs2;
      r_img_valid <= r_act2;
      r_img_data  <= r_act2 ? pix_rd_data : 8'd0;
    end
  end

  assign pix_rd_en   = r_rd_en;
  assign pix_rd_addr = r_addr;
  assign img_vsync   = r_img_vs;
  assign img_hsync   = r_img_hs;
  assign img_valid   = r_img_valid;
  assign img_data    = r_img_data;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vid_timing_ctrl.sv
// tb/tb_vid_timing_ctrl.sv - scoreboard bench for vid_timing_ctrl on a 20x20 raster
module tb_vid_timing_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          pix_rd_en;
  logic [AW-1:0] pix_rd_addr;
  logic [7:0]    pix_rd_data = 8'd0;
  logic          img_vsync, img_hsync, img_valid;
  logic [7:0]    img_data;
  logic          busy, frame_done;
  logic [15:0]   frame_cnt;

  vid_timing_ctrl #(
    .H_SYNC(1), .H_BACK(2), .H_DISP(15), .H_FRONT(2), .H_TOTAL(20),
    .V_SYNC(1), .V_BACK(2), .V_DISP(15), .V_FRONT(2), .V_TOTAL(20),
    .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .img_vsync(img_vsync), .img_hsync(img_hsync), .img_valid(img_valid),
    .img_data(img_data), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Pixel RAM: content equals the low byte of the address, one cycle read latency
  always @(posedge clk) if (pix_rd_en) pix_rd_data <= pix_rd_addr[7:0];

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  int          fd_pos[$];

  always @(negedge clk) begin
    if (img_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL img_unexpected actual=%0d required=no_pixel", img_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (img_data !== mon_exp) begin
          failures++;
          $display("FAIL img_data actual=%0d required=%0d", img_data, mon_exp);
        end
      end
    end else begin
      checks++;
      if (img_data !== 8'd0) begin
        failures++;
        $display("FAIL img_data_idle actual=%0d required=0", img_data);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
  endtask

  function automatic longint outs_word();
    return longint'({pix_rd_en, pix_rd_addr, img_vsync, img_hsync, img_valid,
                     img_data, busy, frame_done, frame_cnt});
  endfunction

  // Samples n consecutive cycles (current first), leaving the bench in the following cycle
  task automatic run_count(input int n, output int nv, output int nh, output int nval,
                           output int nfd, output int nbusy_low);
    nv = 0; nh = 0; nval = 0; nfd = 0; nbusy_low = 0;
    fd_pos.delete();
    for (int i = 0; i < n; i++) begin
      nv += int'(img_vsync);
      nh += int'(img_hsync);
      nval += int'(img_valid);
      if (frame_done) begin
        nfd++;
        fd_pos.push_back(i);
      end
      if (!busy) nbusy_low++;
      step();
    end
  endtask

  int nv, nh, nval, nfd, nbl;
  int nv2, nh2, nval2, nfd2, nbl2;
  int nv3, nh3, nval3, nfd3, nbl3;
  bit found;

  initial begin
    repeat (3) step();
    check("reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
    step();
    check("idle_outputs", outs_word(), 0);

    push_pixels(225); push_pixels(225); push_pixels(225); push_pixels(225);
    en = 1'b1;
    repeat (3) step();
    check("vsync_latency3", img_vsync, 0);
    step();
    check("vsync_latency4", img_vsync, 1);

    run_count(1200, nv, nh, nval, nfd, nbl);
    check("vsync_clocks_3f", nv, 60);
    check("hsync_clocks_3f", nh, 60);
    check("valid_count_3f", nval, 675);
    check("frame_done_count_3f", nfd, 3);
    check("frame_done_pos0", fd_pos.size() > 0 ? fd_pos[0] : -1, 396);
    check("frame_done_pos1", fd_pos.size() > 1 ? fd_pos[1] : -1, 796);
    check("frame_done_pos2", fd_pos.size() > 2 ? fd_pos[2] : -1, 1196);
    check("busy_low_3f", nbl, 0);
    check("frame_cnt_3f", frame_cnt, 3);

    run_count(100, nv, nh, nval, nfd, nbl);
    en = 1'b0;
    run_count(300, nv2, nh2, nval2, nfd2, nbl2);
    check("stop_valid_count", nval + nval2, 225);
    check("stop_frame_done", nfd + nfd2, 1);
    check("stop_busy_low", nbl + nbl2, 3);
    check("stop_outputs_zero", outs_word() & ~longint'(16'hFFFF), 0);
    check("stop_frame_cnt", frame_cnt, 4);
    check("stop_queue_empty", exp_q.size(), 0);

    push_pixels(225); push_pixels(225);
    en = 1'b1;
    repeat (4) step();
    run_count(100, nv, nh, nval, nfd, nbl);
    en = 1'b0;
    run_count(5, nv2, nh2, nval2, nfd2, nbl2);
    en = 1'b1;
    run_count(295, nv3, nh3, nval3, nfd3, nbl3);
    check("glitch_frame_valid", nval + nval2 + nval3, 225);
    check("glitch_busy_low", nbl + nbl2 + nbl3, 0);
    check("glitch_frame_done", nfd + nfd2 + nfd3, 1);
    run_count(100, nv, nh, nval, nfd, nbl);
    check("glitch_next_busy", nbl, 0);
    en = 1'b0;
    run_count(300, nv2, nh2, nval2, nfd2, nbl2);
    check("glitch_next_valid", nval + nval2, 225);
    check("glitch_end_busy_low", nbl2, 3);
    check("glitch_frame_cnt", frame_cnt, 6);
    check("glitch_queue_empty", exp_q.size(), 0);

    push_pixels(99);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (pix_rd_en && pix_rd_addr == AW'(100)) found = 1'b1;
      else step();
    end
    check("reset_point_found", found, 1);
    rst_n = 1'b0;
    step();
    check("midframe_reset_outputs", outs_word(), 0);
    check("midframe_reset_queue", exp_q.size(), 0);
    push_pixels(225);
    rst_n = 1'b1;
    repeat (4) step();
    check("restart_vsync", img_vsync, 1);
    run_count(100, nv, nh, nval, nfd, nbl);
    en = 1'b0;
    run_count(300, nv2, nh2, nval2, nfd2, nbl2);
    check("restart_valid", nval + nval2, 225);
    check("restart_frame_cnt", frame_cnt, 1);
    step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
